// File: rtl/plic_lite_if.sv
// Register port between the core data side and the PLIC.
// The core drives strobes, address and write data; the PLIC returns read data.
interface plic_lite_if;
  logic        core_wen;
  logic        core_ren;
  logic [23:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;

  modport master (
    output core_wen,
    output core_ren,
    output core_addr,
    output core_wdata,
    input  core_rdata
  );

  modport slave (
    input  core_wen,
    input  core_ren,
    input  core_addr,
    input  core_wdata,
    output core_rdata
  );
endinterface

// File: rtl/plic_lite.sv
// Lightweight PLIC: level gateways, priority/threshold arbitration,
// claim/complete through a memory-mapped register port.
module plic_lite #(
  parameter int NUM_SRC = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] intr_bundle,
  plic_lite_if.slave         bus,
  output logic               plic_notif
);
  localparam int IDW = 5;

  logic [PRIO_W-1:0]  r_prio [1:NUM_SRC];
  logic [NUM_SRC:1]   r_en;
  logic [NUM_SRC:1]   r_pend;
  logic [NUM_SRC:1]   r_insvc;
  logic [PRIO_W-1:0]  r_thr;
  logic [31:0]        r_rdata;
  logic               r_notif;

  logic [IDW-1:0]     w_best;
  logic [PRIO_W-1:0]  w_bprio;
  logic [9:0]         w_pidx;
  logic               w_psel;
  logic               w_spnd;
  logic               w_sen;
  logic               w_sthr;
  logic               w_sclm;
  logic               w_claim;
  logic               w_cmpl;
  logic [IDW-1:0]     w_cid;
  logic [PRIO_W-1:0]  w_pval;
  logic [31:0]        w_rval;
  logic               w_unused;

  // Seeding with the threshold makes "> threshold" and strict-greater
  // tie-breaking (lowest ID wins) a single comparison.
  always_comb begin
    w_best  = '0;
    w_bprio = r_thr;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (r_en[i] && r_pend[i] && (r_prio[i] > w_bprio)) begin
        w_best  = IDW'(i);
        w_bprio = r_prio[i];
      end
    end
  end

  assign w_pidx = bus.core_addr[11:2];
  assign w_psel = (bus.core_addr[23:12] == 12'h0)
               && (bus.core_addr[1:0] == 2'b00)
               && (w_pidx != 10'd0)
               && (w_pidx <= 10'(NUM_SRC));
  assign w_spnd = (bus.core_addr == 24'h001000);
  assign w_sen  = (bus.core_addr == 24'h002000);
  assign w_sthr = (bus.core_addr == 24'h200000);
  assign w_sclm = (bus.core_addr == 24'h200004);

  assign w_claim = bus.core_ren && w_sclm && (w_best != '0);
  assign w_cmpl  = bus.core_wen && w_sclm;
  assign w_cid   = bus.core_wdata[IDW-1:0];
  assign w_unused = ^bus.core_wdata;

  always_comb begin
    w_pval = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (w_pidx == 10'(i)) w_pval = r_prio[i];
    end
  end

  always_comb begin
    w_rval = '0;
    unique case (1'b1)
      w_psel: w_rval[PRIO_W-1:0] = w_pval;
      w_spnd: w_rval[NUM_SRC:1]  = r_pend;
      w_sen:  w_rval[NUM_SRC:1]  = r_en;
      w_sthr: w_rval[PRIO_W-1:0] = r_thr;
      w_sclm: w_rval[IDW-1:0]    = w_best;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NUM_SRC; i++) r_prio[i] <= '0;
      r_en    <= '0;
      r_pend  <= '0;
      r_insvc <= '0;
      r_thr   <= '0;
      r_rdata <= '0;
      r_notif <= 1'b0;
    end else begin
      if (bus.core_ren) r_rdata <= w_rval;
      r_notif <= (w_best != '0);
      if (bus.core_wen) begin
        for (int i = 1; i <= NUM_SRC; i++) begin
          if (w_psel && (w_pidx == 10'(i)))
            r_prio[i] <= bus.core_wdata[PRIO_W-1:0];
        end
        if (w_sen)  r_en  <= bus.core_wdata[NUM_SRC:1];
        if (w_sthr) r_thr <= bus.core_wdata[PRIO_W-1:0];
      end
      // Gateway sees the pre-edge in_service, so a complete only
      // lets the line re-pend on the following edge.
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (w_claim && (w_best == IDW'(i))) begin
          r_pend[i]  <= 1'b0;
          r_insvc[i] <= 1'b1;
        end else begin
          if (intr_bundle[i-1] && !r_pend[i] && !r_insvc[i])
            r_pend[i] <= 1'b1;
          if (w_cmpl && (w_cid == IDW'(i)))
            r_insvc[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.core_rdata = r_rdata;
  assign plic_notif     = r_notif;
endmodule

// File: tb/tb_plic_lite.sv
// Directed bench for plic_lite: read results go through an expectation
// queue, notif and reset state are checked against fixed values.
module tb_plic_lite;
  logic       clk;
  logic       rst;
  logic [7:0] intr;
  logic       notif;
  int         checks;
  int         errors;
  logic [31:0] exp_q [$];

  localparam logic [23:0] A_PND = 24'h001000;
  localparam logic [23:0] A_EN  = 24'h002000;
  localparam logic [23:0] A_THR = 24'h200000;
  localparam logic [23:0] A_CLM = 24'h200004;

  plic_lite_if bus ();

  plic_lite #(
    .NUM_SRC(8),
    .PRIO_W (3)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .intr_bundle(intr),
    .bus        (bus),
    .plic_notif (notif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d);
    bus.core_wen   = 1'b1;
    bus.core_addr  = a;
    bus.core_wdata = d;
    tick();
    bus.core_wen   = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [23:0] a,
                    input logic [31:0] e);
    bus.core_ren  = 1'b1;
    bus.core_addr = a;
    exp_q.push_back(e);
    tick();
    bus.core_ren  = 1'b0;
    chk(tag, bus.core_rdata, exp_q.pop_front());
  endtask

  task automatic rw(input string tag,
                    input logic [23:0] a,
                    input logic [31:0] d,
                    input logic [31:0] e);
    bus.core_wen   = 1'b1;
    bus.core_ren   = 1'b1;
    bus.core_addr  = a;
    bus.core_wdata = d;
    exp_q.push_back(e);
    tick();
    bus.core_wen   = 1'b0;
    bus.core_ren   = 1'b0;
    chk(tag, bus.core_rdata, exp_q.pop_front());
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    intr = '0;
    bus.core_wen = 1'b0;
    bus.core_ren = 1'b0;
    bus.core_addr = '0;
    bus.core_wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rdata", bus.core_rdata, 32'h0);
    chk("rst_notif", {31'h0, notif}, 32'h0);
    rd("rst_thr", A_THR, 32'h0);
    rd("rst_en", A_EN, 32'h0);

    // T1: single source, two-cycle notif latency
    wr(24'h00000C, 32'd5);
    wr(A_EN, 32'h08);
    wr(A_THR, 32'd0);
    intr = 8'h04;
    tick();
    chk("t1_notif_1cyc", {31'h0, notif}, 32'h0);
    tick();
    chk("t1_notif_2cyc", {31'h0, notif}, 32'h1);
    rd("t1_claim", A_CLM, 32'd3);
    rd("t1_pend_clr", A_PND, 32'h0);
    chk("t1_notif_fall", {31'h0, notif}, 32'h0);
    intr = 8'h00;
    wr(A_CLM, 32'd3);

    // T2: priority ordering with tie on lowest ID
    wr(24'h00000C, 32'd0);
    wr(24'h000008, 32'd4);
    wr(24'h000014, 32'd4);
    wr(24'h000018, 32'd6);
    wr(A_EN, 32'h1FE);
    intr = 8'h32;
    tick();
    intr = 8'h00;
    tick();
    chk("t2_notif", {31'h0, notif}, 32'h1);
    rd("t2_claim6", A_CLM, 32'd6);
    wr(A_CLM, 32'd6);
    rd("t2_claim2", A_CLM, 32'd2);
    wr(A_CLM, 32'd2);
    rd("t2_claim5", A_CLM, 32'd5);
    wr(A_CLM, 32'd5);
    rd("t2_claim_none", A_CLM, 32'd0);

    // T3: threshold masks equal priority
    wr(A_THR, 32'd4);
    wr(24'h000004, 32'd4);
    intr = 8'h01;
    tick();
    tick();
    tick();
    chk("t3_masked", {31'h0, notif}, 32'h0);
    wr(A_THR, 32'd3);
    chk("t3_notif_1cyc", {31'h0, notif}, 32'h0);
    tick();
    chk("t3_notif_2cyc", {31'h0, notif}, 32'h1);
    rd("t3_claim1", A_CLM, 32'd1);
    intr = 8'h00;
    wr(A_CLM, 32'd1);

    // T4: in-service blocks re-pend; bogus complete ignored
    wr(24'h00000C, 32'd5);
    intr = 8'h04;
    tick();
    tick();
    chk("t4_notif", {31'h0, notif}, 32'h1);
    rd("t4_claim3", A_CLM, 32'd3);
    tick();
    tick();
    rd("t4_no_repend", A_PND, 32'h0);
    wr(A_CLM, 32'd7);
    rd("t4_bad_cmpl", A_PND, 32'h0);
    chk("t4_notif_low", {31'h0, notif}, 32'h0);
    wr(A_CLM, 32'd3);
    rd("t4_pend_edge", A_PND, 32'h0);
    rd("t4_repend", A_PND, 32'h08);

    // T5: empty claim, then reset while in service
    intr = 8'h00;
    rd("t5_claim3", A_CLM, 32'd3);
    rd("t5_claim_empty", A_CLM, 32'd0);
    rd("t5_pend", A_PND, 32'h0);
    chk("t5_notif", {31'h0, notif}, 32'h0);
    rd("t5_thr", A_THR, 32'd3);
    intr = 8'h01;
    tick();
    tick();
    chk("t5_notif_pre", {31'h0, notif}, 32'h1);
    intr = 8'h00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_rdata", bus.core_rdata, 32'h0);
    chk("t5_rst_notif", {31'h0, notif}, 32'h0);
    rd("t5_rst_prio3", 24'h00000C, 32'h0);
    rd("t5_rst_en", A_EN, 32'h0);
    rd("t5_rst_thr", A_THR, 32'h0);
    rd("t5_rst_pend", A_PND, 32'h0);
    wr(24'h00000C, 32'd5);
    wr(A_EN, 32'h08);
    intr = 8'h04;
    tick();
    tick();
    chk("t5_svc_clr", {31'h0, notif}, 32'h1);
    rd("t5_claim_again", A_CLM, 32'd3);
    intr = 8'h00;
    wr(A_CLM, 32'd3);

    // T6: pending map, unmapped space, truncation, write+read
    wr(24'h000004, 32'd1);
    wr(24'h000010, 32'd1);
    wr(A_EN, 32'h12);
    intr = 8'h09;
    tick();
    intr = 8'h00;
    rd("t6_pend", A_PND, 32'h12);
    rd("t6_unmapped", 24'h003000, 32'h0);
    wr(24'h000008, 32'hF);
    rd("t6_trunc", 24'h000008, 32'd7);
    rw("t6_rw_old", A_THR, 32'd7, 32'd0);
    rd("t6_rw_new", A_THR, 32'd7);
    wr(24'h002004, 32'hFF);
    rd("t6_wr_ignored", A_EN, 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
